// File: rtl/chipinvaders_pkg.sv
// Shared types and constants for the chipinvaders alien fleet.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: fleet_state_t, formation size defaults, per-row score values
// and the row -> points helper.
package chipinvaders_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MARCH   = 2'd1,
        CLEARED = 2'd2,
        LANDED  = 2'd3
    } fleet_state_t;

    localparam int ROWS_DEF = 5;
    localparam int COLS_DEF = 11;

    localparam logic [5:0] PTS_TOP = 6'd30;   // row 0
    localparam logic [5:0] PTS_MID = 6'd20;   // rows 1-2
    localparam logic [5:0] PTS_LOW = 6'd10;   // rows 3 and below

    function automatic logic [5:0] row_points(input logic [2:0] row);
        logic [5:0] pts;
        if (row == 3'd0) begin
            pts = PTS_TOP;
        end else if (row <= 3'd2) begin
            pts = PTS_MID;
        end else begin
            pts = PTS_LOW;
        end
        return pts;
    endfunction

endpackage

// File: rtl/fleet_extent.sv
// Occupied extent of the formation: lowest/highest live column, lowest live row.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: i_alive (mask, bit = row*COLS+col) -> o_min_col, o_max_col, o_max_row,
// o_any_alive. With an empty mask the indices read 0 and o_any_alive is 0.
module fleet_extent
    import chipinvaders_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
)
(
    input  logic [ROWS*COLS-1:0] i_alive,
    output logic [3:0]           o_min_col,
    output logic [3:0]           o_max_col,
    output logic [2:0]           o_max_row,
    output logic                 o_any_alive
);

    logic [COLS-1:0] w_col_any;
    logic [ROWS-1:0] w_row_any;

    always_comb begin
        w_col_any = '0;
        w_row_any = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (i_alive[r*COLS+c]) begin
                    w_col_any[c] = 1'b1;
                    w_row_any[r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_min_col = '0;
        o_max_col = '0;
        o_max_row = '0;
        // Descending scan so the last hit is the lowest column.
        for (int c = COLS-1; c >= 0; c--) begin
            if (w_col_any[c]) o_min_col = 4'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (w_col_any[c]) o_max_col = 4'(c);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (w_row_any[r]) o_max_row = 3'(r);
        end
    end

    assign o_any_alive = |w_row_any;

endmodule

// File: rtl/alien_fleet_ctrl.sv
// Alien formation sequencer: march timing, stepping, edge drop, kills, score events.
// Latency: kill_ack/kill_hit/score one cycle after kill_valid; steps on vsync rising edge.
// Backpressure: none; kill_valid accepted every cycle, every request gets an ack.
//
// Ports: clk, reset (async, active-high), vsync, start, kill_valid/kill_row/kill_col in;
// kill_ack, kill_hit, score_pulse, score_points, fleet_x, fleet_y, alive, alive_count,
// anim_phase, fleet_cleared, fleet_landed out.
// Build option: define FLEET_SPEEDUP_EN to make the step period shrink with alive_count;
// otherwise the period is the constant BASE_PERIOD.
module alien_fleet_ctrl
    import chipinvaders_pkg::*;
#(
    parameter int ROWS        = ROWS_DEF,
    parameter int COLS        = COLS_DEF,
    parameter int CELL_W      = 32,
    parameter int CELL_H      = 24,
    parameter int START_X     = 64,
    parameter int START_Y     = 64,
    parameter int STEP_X      = 4,
    parameter int DROP_Y      = 12,
    parameter int LEFT_LIMIT  = 8,
    parameter int RIGHT_LIMIT = 632,
    parameter int LAND_Y      = 424,
    parameter int BASE_PERIOD = 30,
    parameter int MIN_PERIOD  = 2
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vsync,
    input  logic                 start,
    input  logic                 kill_valid,
    input  logic [2:0]           kill_row,
    input  logic [3:0]           kill_col,
    output logic                 kill_ack,
    output logic                 kill_hit,
    output logic                 score_pulse,
    output logic [5:0]           score_points,
    output logic [9:0]           fleet_x,
    output logic [9:0]           fleet_y,
    output logic [ROWS*COLS-1:0] alive,
    output logic [5:0]           alive_count,
    output logic                 anim_phase,
    output logic                 fleet_cleared,
    output logic                 fleet_landed
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N);

    fleet_state_t   r_state, w_state_nxt;
    logic           r_vsync_q;
    logic [5:0]     r_frame_cnt;
    logic [N-1:0]   r_alive;
    logic [5:0]     r_alive_count;
    logic [9:0]     r_fleet_x, r_fleet_y;
    logic           r_dir_left;
    logic           r_anim;
    logic           r_edge_right, r_edge_left, r_land_cmp;
    logic           r_kill_ack, r_kill_hit, r_score_pulse;
    logic [5:0]     r_score_points;

    logic           w_tick;
    logic [5:0]     w_period;
    logic           w_step;
    logic           w_kill_hit;
    logic           w_kill_in_range;
    logic           w_target_alive;
    logic [IDX_W-1:0] w_kill_idx;
    logic [3:0]     w_min_col, w_max_col;
    logic [2:0]     w_max_row;
    logic           w_any_alive;
    logic [10:0]    w_left, w_right, w_bottom;

    assign w_tick = vsync & ~r_vsync_q;

`ifdef FLEET_SPEEDUP_EN
    logic [5:0] w_half_count;
    assign w_half_count = {1'b0, r_alive_count[5:1]};
    assign w_period     = (w_half_count < 6'(MIN_PERIOD)) ? 6'(MIN_PERIOD) : w_half_count;
`else
    localparam int PERIOD_CONST = (BASE_PERIOD < MIN_PERIOD) ? MIN_PERIOD : BASE_PERIOD;
    assign w_period = 6'(PERIOD_CONST);
`endif

    fleet_extent #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_extent (
        .i_alive     (r_alive),
        .o_min_col   (w_min_col),
        .o_max_col   (w_max_col),
        .o_max_row   (w_max_row),
        .o_any_alive (w_any_alive)
    );

    // Edge positions in 11 bits so the limit compares cannot wrap.
    assign w_left   = {1'b0, r_fleet_x} + 11'(w_min_col) * 11'(CELL_W);
    assign w_right  = {1'b0, r_fleet_x} + (11'(w_max_col) + 11'd1) * 11'(CELL_W);
    assign w_bottom = {1'b0, r_fleet_y} + (11'(w_max_row) + 11'd1) * 11'(CELL_H);

    always_comb begin
        w_kill_in_range = (int'(kill_row) < ROWS) && (int'(kill_col) < COLS);
        w_kill_idx      = IDX_W'(int'(kill_row) * COLS + int'(kill_col));
        w_target_alive  = w_kill_in_range ? r_alive[w_kill_idx] : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Step decisions use registered edge/land compares, i.e. the pre-kill mask.
    always_comb begin
        w_state_nxt = r_state;
        w_kill_hit  = 1'b0;
        w_step      = 1'b0;
        if (!start && r_state == MARCH) begin
            w_kill_hit = kill_valid && w_target_alive;
            w_step     = w_tick && (r_frame_cnt + 6'd1 >= w_period) && !r_land_cmp;
        end
        if (start) begin
            w_state_nxt = MARCH;
        end else begin
            case (r_state)
                MARCH: begin
                    // Clearing the last alien takes priority over landing.
                    if (w_kill_hit && r_alive_count == 6'd1) begin
                        w_state_nxt = CLEARED;
                    end else if (r_land_cmp) begin
                        w_state_nxt = LANDED;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vsync_q      <= 1'b0;
            r_frame_cnt    <= '0;
            r_alive        <= '0;
            r_alive_count  <= '0;
            r_fleet_x      <= 10'(START_X);
            r_fleet_y      <= 10'(START_Y);
            r_dir_left     <= 1'b0;
            r_anim         <= 1'b0;
            r_edge_right   <= 1'b0;
            r_edge_left    <= 1'b0;
            r_land_cmp     <= 1'b0;
            r_kill_ack     <= 1'b0;
            r_kill_hit     <= 1'b0;
            r_score_pulse  <= 1'b0;
            r_score_points <= '0;
        end else begin
            r_vsync_q      <= vsync;
            r_kill_ack     <= kill_valid;
            r_kill_hit     <= w_kill_hit;
            r_score_pulse  <= w_kill_hit;
            r_score_points <= w_kill_hit ? row_points(kill_row) : 6'd0;

            if (start) begin
                r_alive       <= {N{1'b1}};
                r_alive_count <= 6'(N);
                r_fleet_x     <= 10'(START_X);
                r_fleet_y     <= 10'(START_Y);
                r_dir_left    <= 1'b0;
                r_frame_cnt   <= '0;
                // Cleared so stale compares from the previous game cannot fire.
                r_edge_right  <= 1'b0;
                r_edge_left   <= 1'b0;
                r_land_cmp    <= 1'b0;
            end else begin
                r_edge_right <= w_any_alive && (w_right + 11'(STEP_X) > 11'(RIGHT_LIMIT));
                r_edge_left  <= w_any_alive && (w_left < 11'(LEFT_LIMIT + STEP_X));
                r_land_cmp   <= w_any_alive && (w_bottom >= 11'(LAND_Y));

                if (w_kill_hit) begin
                    r_alive[w_kill_idx] <= 1'b0;
                    r_alive_count       <= r_alive_count - 6'd1;
                end

                if (r_state == MARCH && w_tick) begin
                    r_frame_cnt <= w_step ? 6'd0 : r_frame_cnt + 6'd1;
                end

                if (w_step) begin
                    r_anim <= ~r_anim;
                    if (r_dir_left ? r_edge_left : r_edge_right) begin
                        r_fleet_y  <= r_fleet_y + 10'(DROP_Y);
                        r_dir_left <= ~r_dir_left;
                    end else if (r_dir_left) begin
                        r_fleet_x <= r_fleet_x - 10'(STEP_X);
                    end else begin
                        r_fleet_x <= r_fleet_x + 10'(STEP_X);
                    end
                end
            end
        end
    end

    assign kill_ack      = r_kill_ack;
    assign kill_hit      = r_kill_hit;
    assign score_pulse   = r_score_pulse;
    assign score_points  = r_score_points;
    assign fleet_x       = r_fleet_x;
    assign fleet_y       = r_fleet_y;
    assign alive         = r_alive;
    assign alive_count   = r_alive_count;
    assign anim_phase    = r_anim;
    assign fleet_cleared = (r_state == CLEARED);
    assign fleet_landed  = (r_state == LANDED);

endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// Directed bench for alien_fleet_ctrl: a default-parameter instance plus a
// fast-march instance (BASE_PERIOD=2) sharing the same inputs, used where
// many steps are needed (edge shrink, landing).
module tb_alien_fleet_ctrl;

`ifdef FLEET_SPEEDUP_EN
    localparam int FULL_PERIOD = 27;   // 55 >> 1
    localparam int LAST_PERIOD = 2;    // max(2, 1 >> 1)
`else
    localparam int FULL_PERIOD = 30;
    localparam int LAST_PERIOD = 30;
`endif

    logic        clk = 1'b0;
    logic        reset, vsync, start, kill_valid;
    logic [2:0]  kill_row;
    logic [3:0]  kill_col;

    logic        kill_ack, kill_hit, score_pulse, anim_phase, fleet_cleared, fleet_landed;
    logic [5:0]  score_points, alive_count;
    logic [9:0]  fleet_x, fleet_y;
    logic [54:0] alive;

    logic        f_kill_ack, f_kill_hit, f_score_pulse, f_anim_phase, f_fleet_cleared, f_fleet_landed;
    logic [5:0]  f_score_points, f_alive_count;
    logic [9:0]  f_fleet_x, f_fleet_y;
    logic [54:0] f_alive;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alien_fleet_ctrl u_dut (
        .clk(clk), .reset(reset), .vsync(vsync), .start(start),
        .kill_valid(kill_valid), .kill_row(kill_row), .kill_col(kill_col),
        .kill_ack(kill_ack), .kill_hit(kill_hit), .score_pulse(score_pulse),
        .score_points(score_points), .fleet_x(fleet_x), .fleet_y(fleet_y),
        .alive(alive), .alive_count(alive_count), .anim_phase(anim_phase),
        .fleet_cleared(fleet_cleared), .fleet_landed(fleet_landed)
    );

    alien_fleet_ctrl #(.BASE_PERIOD(2)) u_fast (
        .clk(clk), .reset(reset), .vsync(vsync), .start(start),
        .kill_valid(kill_valid), .kill_row(kill_row), .kill_col(kill_col),
        .kill_ack(f_kill_ack), .kill_hit(f_kill_hit), .score_pulse(f_score_pulse),
        .score_points(f_score_points), .fleet_x(f_fleet_x), .fleet_y(f_fleet_y),
        .alive(f_alive), .alive_count(f_alive_count), .anim_phase(f_anim_phase),
        .fleet_cleared(f_fleet_cleared), .fleet_landed(f_fleet_landed)
    );

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        vsync = 1'b1;
        cyc();
        vsync = 1'b0;
        cyc();
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic kill_one(input int r, input int c);
        kill_valid = 1'b1;
        kill_row   = 3'(r);
        kill_col   = 4'(c);
        cyc();
        kill_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; vsync = 1'b0; start = 1'b0; kill_valid = 1'b0; kill_row = '0; kill_col = '0;
        #2 reset = 1'b1;
        #1;
        checks++; if (fleet_x !== 10'd64) begin errors++; $display("FAIL rst_x got %0d exp 64", fleet_x); end
        checks++; if (fleet_y !== 10'd64) begin errors++; $display("FAIL rst_y got %0d exp 64", fleet_y); end
        checks++; if (alive !== 55'd0 || alive_count !== 6'd0) begin errors++; $display("FAIL rst_alive got %h/%0d exp 0/0", alive, alive_count); end
        checks++; if ({kill_ack, kill_hit, score_pulse, anim_phase, fleet_cleared, fleet_landed} !== 6'b0) begin
            errors++; $display("FAIL rst_flags got %b exp 000000", {kill_ack, kill_hit, score_pulse, anim_phase, fleet_cleared, fleet_landed}); end
        @(posedge clk); #1 reset = 1'b0;
        kill_one(0, 0);
        checks++; if (kill_ack !== 1'b1 || kill_hit !== 1'b0 || score_pulse !== 1'b0) begin
            errors++; $display("FAIL idle_kill got ack%b hit%b pulse%b exp ack1 hit0 pulse0", kill_ack, kill_hit, score_pulse); end
        repeat (4) tick();
        checks++; if (fleet_x !== 10'd64 || anim_phase !== 1'b0) begin errors++; $display("FAIL idle_nostep got x%0d anim%b exp x64 anim0", fleet_x, anim_phase); end
    endtask

    task automatic test_first_step();
        do_start();
        checks++; if (alive_count !== 6'd55 || alive !== {55{1'b1}} || fleet_x !== 10'd64) begin
            errors++; $display("FAIL start got cnt%0d x%0d mask %h exp cnt55 x64 all-ones", alive_count, fleet_x, alive); end
        repeat (FULL_PERIOD - 1) tick();
        checks++; if (fleet_x !== 10'd64 || anim_phase !== 1'b0) begin errors++; $display("FAIL pre_step got x%0d anim%b exp x64 anim0", fleet_x, anim_phase); end
        tick();
        checks++; if (fleet_x !== 10'd68 || anim_phase !== 1'b1) begin errors++; $display("FAIL first_step got x%0d anim%b exp x68 anim1", fleet_x, anim_phase); end
    endtask

    task automatic test_march_edge();
        int steps;
        logic [9:0] px;
        steps = 1;
        for (int i = 0; i < 3000 && fleet_y == 10'd64; i++) begin
            px = fleet_x;
            tick();
            if (fleet_x != px || fleet_y != 10'd64) steps++;
        end
        checks++; if (steps != 55 || fleet_x !== 10'd280 || fleet_y !== 10'd76) begin
            errors++; $display("FAIL edge_drop got steps%0d x%0d y%0d exp steps55 x280 y76", steps, fleet_x, fleet_y); end
        checks++; if (anim_phase !== 1'b1) begin errors++; $display("FAIL edge_anim got %b exp 1", anim_phase); end
        px = fleet_x;
        for (int i = 0; i < 40 && fleet_x == px; i++) tick();
        checks++; if (fleet_x !== 10'd276 || fleet_y !== 10'd76) begin errors++; $display("FAIL march_left got x%0d y%0d exp x276 y76", fleet_x, fleet_y); end
    endtask

    task automatic test_kill();
        do_start();
        kill_one(0, 3);
        checks++; if (kill_ack !== 1'b1 || kill_hit !== 1'b1 || score_pulse !== 1'b1 || score_points !== 6'd30) begin
            errors++; $display("FAIL kill03 got ack%b hit%b pulse%b pts%0d exp 1 1 1 30", kill_ack, kill_hit, score_pulse, score_points); end
        checks++; if (alive_count !== 6'd54 || alive[3] !== 1'b0) begin errors++; $display("FAIL kill03_mask got cnt%0d bit%b exp cnt54 bit0", alive_count, alive[3]); end
        cyc();
        checks++; if (kill_ack !== 1'b0 || score_pulse !== 1'b0) begin errors++; $display("FAIL ack_pulse_len got ack%b pulse%b exp 0 0", kill_ack, score_pulse); end
        kill_one(0, 3);
        checks++; if (kill_ack !== 1'b1 || kill_hit !== 1'b0 || score_pulse !== 1'b0 || alive_count !== 6'd54) begin
            errors++; $display("FAIL rekill got ack%b hit%b pulse%b cnt%0d exp 1 0 0 54", kill_ack, kill_hit, score_pulse, alive_count); end
        kill_one(2, 5);
        checks++; if (kill_hit !== 1'b1 || score_points !== 6'd20) begin errors++; $display("FAIL kill25 got hit%b pts%0d exp 1 20", kill_hit, score_points); end
        kill_one(4, 10);
        checks++; if (kill_hit !== 1'b1 || score_points !== 6'd10 || alive_count !== 6'd52) begin
            errors++; $display("FAIL kill4a got hit%b pts%0d cnt%0d exp 1 10 52", kill_hit, score_points, alive_count); end
        kill_valid = 1'b1;
        kill_row   = 3'd1;
        for (int c = 0; c < 3; c++) begin
            kill_col = 4'(c);
            cyc();
            checks++; if (kill_ack !== 1'b1 || kill_hit !== 1'b1 || score_points !== 6'd20) begin
                errors++; $display("FAIL b2b_%0d got ack%b hit%b pts%0d exp 1 1 20", c, kill_ack, kill_hit, score_points); end
        end
        kill_valid = 1'b0;
        checks++; if (alive_count !== 6'd49) begin errors++; $display("FAIL b2b_cnt got %0d exp 49", alive_count); end
    endtask

    task automatic test_column_and_range();
        logic [54:0] exp_mask;
        exp_mask = {55{1'b1}};
        do_start();
        for (int r = 0; r < 5; r++) begin
            kill_one(r, 10);
            exp_mask[r*11+10] = 1'b0;
            checks++; if (kill_hit !== 1'b1) begin errors++; $display("FAIL col10_r%0d got hit%b exp 1", r, kill_hit); end
        end
        checks++; if (alive !== exp_mask || alive_count !== 6'd50) begin
            errors++; $display("FAIL col10_mask got %h cnt%0d exp %h cnt50", alive, alive_count, exp_mask); end
        kill_one(7, 12);
        checks++; if (kill_ack !== 1'b1 || kill_hit !== 1'b0) begin errors++; $display("FAIL oob_7_12 got ack%b hit%b exp 1 0", kill_ack, kill_hit); end
        kill_one(5, 0);
        checks++; if (kill_hit !== 1'b0) begin errors++; $display("FAIL oob_row5 got hit%b exp 0", kill_hit); end
        kill_one(0, 11);
        checks++; if (kill_hit !== 1'b0 || alive !== exp_mask) begin errors++; $display("FAIL oob_col11 got hit%b mask %h exp 0 %h", kill_hit, alive, exp_mask); end
        // Right edge is now 64+320: drop at x=312 instead of 280.
        for (int i = 0; i < 2000 && f_fleet_y == 10'd64; i++) tick();
        checks++; if (f_fleet_x !== 10'd312 || f_fleet_y !== 10'd76) begin
            errors++; $display("FAIL shrunk_edge got x%0d y%0d exp x312 y76", f_fleet_x, f_fleet_y); end
    endtask

    task automatic test_clear_with_step();
        do_start();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 11; c++) kill_one(r, c);
        for (int c = 1; c < 7; c++) kill_one(4, c);
        checks++; if (alive_count !== 6'd5) begin errors++; $display("FAIL five_left got %0d exp 5", alive_count); end
        for (int c = 7; c < 11; c++) kill_one(4, c);
        checks++; if (alive_count !== 6'd1 || alive !== (55'd1 << 44)) begin errors++; $display("FAIL one_left got cnt%0d mask %h", alive_count, alive); end
        repeat (LAST_PERIOD - 1) tick();
        checks++; if (fleet_x !== 10'd64) begin errors++; $display("FAIL pre_final got x%0d exp 64", fleet_x); end
        vsync = 1'b1; kill_valid = 1'b1; kill_row = 3'd4; kill_col = 4'd0;
        cyc();
        vsync = 1'b0; kill_valid = 1'b0;
        checks++; if (fleet_x !== 10'd68 || anim_phase !== 1'b1) begin errors++; $display("FAIL final_step got x%0d anim%b exp x68 anim1", fleet_x, anim_phase); end
        checks++; if (fleet_cleared !== 1'b1 || kill_hit !== 1'b1 || score_pulse !== 1'b1 || score_points !== 6'd10) begin
            errors++; $display("FAIL cleared got clr%b hit%b pulse%b pts%0d exp 1 1 1 10", fleet_cleared, kill_hit, score_pulse, score_points); end
        checks++; if (alive_count !== 6'd0 || alive !== 55'd0 || fleet_landed !== 1'b0) begin
            errors++; $display("FAIL cleared_mask got cnt%0d mask %h land%b exp 0 0 0", alive_count, alive, fleet_landed); end
        cyc();
        repeat (2 * LAST_PERIOD + 4) tick();
        checks++; if (fleet_x !== 10'd68 || fleet_y !== 10'd64 || fleet_cleared !== 1'b1) begin
            errors++; $display("FAIL cleared_hold got x%0d y%0d clr%b exp x68 y64 clr1", fleet_x, fleet_y, fleet_cleared); end
        kill_one(0, 0);
        checks++; if (kill_ack !== 1'b1 || kill_hit !== 1'b0) begin errors++; $display("FAIL cleared_kill got ack%b hit%b exp 1 0", kill_ack, kill_hit); end
    endtask

    task automatic test_landing_and_reset();
        do_start();
        for (int i = 0; i < 6000 && f_fleet_landed !== 1'b1; i++) tick();
        cyc();
        checks++; if (f_fleet_landed !== 1'b1 || f_fleet_y !== 10'd304 || f_fleet_x !== 10'd8) begin
            errors++; $display("FAIL landed got land%b x%0d y%0d exp land1 x8 y304", f_fleet_landed, f_fleet_x, f_fleet_y); end
        repeat (8) tick();
        checks++; if (f_fleet_x !== 10'd8 || f_fleet_y !== 10'd304 || f_fleet_cleared !== 1'b0) begin
            errors++; $display("FAIL landed_hold got x%0d y%0d clr%b exp x8 y304 clr0", f_fleet_x, f_fleet_y, f_fleet_cleared); end
        do_start();
        checks++; if (f_fleet_landed !== 1'b0 || f_alive_count !== 6'd55 || f_fleet_y !== 10'd64) begin
            errors++; $display("FAIL restart got land%b cnt%0d y%0d exp 0 55 64", f_fleet_landed, f_alive_count, f_fleet_y); end
        repeat (3) tick();
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++; if (f_fleet_x !== 10'd64 || f_anim_phase !== 1'b0 || f_alive !== 55'd0 || f_alive_count !== 6'd0) begin
            errors++; $display("FAIL async_rst_fast got x%0d anim%b cnt%0d exp x64 anim0 cnt0", f_fleet_x, f_anim_phase, f_alive_count); end
        checks++; if (fleet_x !== 10'd64 || fleet_y !== 10'd64 || alive_count !== 6'd0 || fleet_landed !== 1'b0 || fleet_cleared !== 1'b0) begin
            errors++; $display("FAIL async_rst_main got x%0d y%0d cnt%0d land%b clr%b", fleet_x, fleet_y, alive_count, fleet_landed, fleet_cleared); end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_first_step();
        test_march_edge();
        test_kill();
        test_column_and_range();
        test_clear_with_step();
        test_landing_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
